// File: rtl/sram_fifo_ctrl_pkg.sv
// rtl/sram_fifo_ctrl_pkg.sv - shared geometry constants for the FIFO controller and sram16x128
// Purpose: single source of truth for the 16-bit x 128-entry SRAM geometry.
// Ports: none (package).
package sram_fifo_ctrl_pkg;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 7;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int COUNT_W = ADDR_W + 1;
endpackage

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - circular-buffer FIFO controller driving a single-port sram16x128
// Purpose: turns a valid/ready push port and a pop-request port into SRAM
//    addr/we/re/inbits. Occupancy is tracked here; pop data comes straight
//    from the SRAM output with a registered valid one cycle after the pop.
// Ports:
//    clk, rst              - rising-edge clock, synchronous active-high reset
//    wr_valid/wr_data/wr_ready - push interface
//    rd_req                - pop request
//    rd_valid/rd_data      - pop data, valid one cycle after an accepted pop
//    full/empty/count      - occupancy (0..128)
//    sram_addr/sram_in/sram_we/sram_re/sram_out - SRAM master interface
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [COUNT_W-1:0] count,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_in,
   output logic              sram_we,
   output logic              sram_re,
   input  logic [DATA_W-1:0] sram_out
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              pop_go;
   logic              push_go;

   assign full  = (count == COUNT_W'(DEPTH));
   assign empty = (count == '0);

   // The SRAM is single-ported: a serviceable pop takes the port and the
   // push waits, so wr_ready must drop whenever a pop will be accepted.
   assign pop_go   = rd_req && !empty && !rst;
   assign wr_ready = !rst && !full && !(rd_req && !empty);
   assign push_go  = wr_valid && wr_ready;

   assign sram_we = push_go;
   assign sram_re = pop_go;
   assign sram_in = wr_data;
   assign rd_data = sram_out;

   // Idle cycles park the address on wr_ptr; reset parks it at zero since
   // wr_ptr still holds its old value during the reset cycle.
   always_comb begin
      sram_addr = wr_ptr;
      if (rst)
         sram_addr = '0;
      else if (pop_go)
         sram_addr = rd_ptr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop_go;
         // push_go and pop_go are mutually exclusive, so count moves by at most one.
         if (push_go) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end else if (pop_go) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl with a behavioural SRAM
module tb_sram_fifo_ctrl;
   import sram_fifo_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready;
   logic              rd_req = 1'b0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              empty;
   logic [COUNT_W-1:0] count;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_in;
   logic              sram_we;
   logic              sram_re;
   logic [DATA_W-1:0] sram_out = '0;

   logic [DATA_W-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   sram_fifo_ctrl dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .full(full), .empty(empty), .count(count),
      .sram_addr(sram_addr), .sram_in(sram_in), .sram_we(sram_we),
      .sram_re(sram_re), .sram_out(sram_out)
   );

   // Behavioural sram16x128: synchronous write, registered read.
   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_in;
      if (sram_re) sram_out <= mem[sram_addr];
   end

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue, SRAM slots as push/pop counts mod DEPTH.
   logic [DATA_W-1:0] mq[$];
   int                wp = 0;
   int                rp = 0;
   bit                model_ok = 0;
   bit                e_rv = 0;
   logic [DATA_W-1:0] e_rd = '0;

   // Observed values from the last step.
   logic              o_wr_ready, o_we, o_re, o_rv, o_full, o_empty;
   logic [ADDR_W-1:0] o_addr;
   logic [COUNT_W-1:0] o_count;
   logic [DATA_W-1:0] o_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check combinational outputs against the
   // model, clock, advance the model, check registered outputs.
   task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d, input logic q);
      int  n;
      bit  e_pop, e_wr_ready, e_push;
      int  e_addr;
      rst = r; wr_valid = v; wr_data = d; rd_req = q;
      #2;
      n          = mq.size();
      e_pop      = q && n > 0 && !r;
      e_wr_ready = !r && n < DEPTH && !(q && n > 0);
      e_push     = v && e_wr_ready;
      e_addr     = r ? 0 : (e_pop ? rp : wp);
      o_wr_ready = wr_ready; o_we = sram_we; o_re = sram_re; o_addr = sram_addr;
      if (model_ok || r) begin
         chk("wr_ready", 32'(wr_ready), 32'(e_wr_ready));
         chk("sram_we", 32'(sram_we), 32'(e_push));
         chk("sram_re", 32'(sram_re), 32'(e_pop));
         chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      end
      if (model_ok) begin
         chk("sram_in", 32'(sram_in), 32'(d));
         chk("count_pre", 32'(count), 32'(n));
         chk("full_pre", 32'(full), 32'(n == DEPTH));
         chk("empty_pre", 32'(empty), 32'(n == 0));
      end
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete(); wp = 0; rp = 0; e_rv = 0; model_ok = 1;
      end else begin
         e_rv = e_pop;
         if (e_pop) begin
            e_rd = mq.pop_front();
            rp = (rp + 1) % DEPTH;
         end
         if (e_push) begin
            mq.push_back(d);
            wp = (wp + 1) % DEPTH;
         end
      end
      o_rv = rd_valid; o_rdata = rd_data; o_count = count; o_full = full; o_empty = empty;
      chk("rd_valid", 32'(rd_valid), 32'(e_rv));
      if (e_rv) chk("rd_data", 32'(rd_data), 32'(e_rd));
      chk("count", 32'(count), 32'(mq.size()));
   endtask

   typedef struct {
      logic              r, v, q;
      logic [DATA_W-1:0] d;
      logic              x_wr_ready, x_we, x_re;
      logic [ADDR_W-1:0] x_addr;
      logic [COUNT_W-1:0] x_count;
      logic              x_rv, x_empty;
      logic [DATA_W-1:0] x_rdata;
   } vec_t;

   vec_t vt[10];

   initial begin
      //        r  v  q  d        rdy we re addr cnt rv emp rdata
      vt[0] = '{1, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0000};
      vt[1] = '{0, 1, 0, 16'h1234, 1, 1, 0, 0, 1, 0, 0, 16'h0000};
      vt[2] = '{0, 1, 0, 16'hBEEF, 1, 1, 0, 1, 2, 0, 0, 16'h0000};
      vt[3] = '{0, 1, 0, 16'h0001, 1, 1, 0, 2, 3, 0, 0, 16'h0000};
      vt[4] = '{0, 0, 1, 16'h0000, 0, 0, 1, 0, 2, 1, 0, 16'h1234};
      vt[5] = '{0, 0, 1, 16'h0000, 0, 0, 1, 1, 1, 1, 0, 16'hBEEF};
      vt[6] = '{0, 0, 1, 16'h0000, 0, 0, 1, 2, 0, 1, 1, 16'h0001};
      vt[7] = '{0, 0, 1, 16'h0000, 1, 0, 0, 3, 0, 0, 1, 16'h0000};
      vt[8] = '{0, 1, 1, 16'h5A5A, 1, 1, 0, 3, 1, 0, 0, 16'h0000};
      vt[9] = '{1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0000};

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("reset_full", 32'(full), 0);
      chk("reset_empty", 32'(empty), 1);

      for (int i = 0; i < 10; i++) begin
         step(vt[i].r, vt[i].v, vt[i].d, vt[i].q);
         chk($sformatf("vec%0d_wr_ready", i), 32'(o_wr_ready), 32'(vt[i].x_wr_ready));
         chk($sformatf("vec%0d_we", i), 32'(o_we), 32'(vt[i].x_we));
         chk($sformatf("vec%0d_re", i), 32'(o_re), 32'(vt[i].x_re));
         chk($sformatf("vec%0d_addr", i), 32'(o_addr), 32'(vt[i].x_addr));
         chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vt[i].x_count));
         chk($sformatf("vec%0d_rv", i), 32'(o_rv), 32'(vt[i].x_rv));
         chk($sformatf("vec%0d_empty", i), 32'(o_empty), 32'(vt[i].x_empty));
         if (vt[i].x_rv) chk($sformatf("vec%0d_rdata", i), 32'(o_rdata), 32'(vt[i].x_rdata));
      end

      // Fill to full, attempt a 129th push, drain.
      step(1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 16'($urandom), 0);
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(count), 128);
      step(0, 1, 16'hDEAD, 0);
      chk("full_no_we", 32'(o_we), 0);
      chk("full_no_ready", 32'(o_wr_ready), 0);
      chk("full_count_hold", 32'(o_count), 128);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
      chk("drain_empty", 32'(empty), 1);

      // Pointer wrap across address 127 -> 0.
      step(1, 0, 0, 0);
      for (int i = 0; i < 100; i++) step(0, 1, 16'($urandom), 0);
      for (int i = 0; i < 100; i++) step(0, 0, 0, 1);
      for (int i = 0; i < 60; i++) begin
         step(0, 1, 16'($urandom), 0);
         if (i == 0)  chk("wrap_first_addr", 32'(o_addr), 100);
         if (i == 27) chk("wrap_last_addr", 32'(o_addr), 127);
         if (i == 28) chk("wrap_zero_addr", 32'(o_addr), 0);
      end
      for (int i = 0; i < 60; i++) begin
         step(0, 0, 0, 1);
         if (i == 28) chk("wrap_pop_addr", 32'(o_addr), 0);
      end

      // Simultaneous push and pop: pop wins, push lands next cycle.
      for (int i = 0; i < 5; i++) step(0, 1, 16'(i + 16'h0A00), 0);
      step(0, 1, 16'hCAFE, 1);
      chk("collide_ready", 32'(o_wr_ready), 0);
      chk("collide_count", 32'(o_count), 4);
      step(0, 1, 16'hCAFE, 0);
      chk("collide_push_count", 32'(o_count), 5);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("empty_pop_re", 32'(o_re), 0);
      chk("empty_pop_rv", 32'(o_rv), 0);

      // Reset while pops are streaming.
      for (int i = 0; i < 4; i++) step(0, 1, 16'($urandom), 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("rst_mid_rv", 32'(o_rv), 0);
      chk("rst_mid_count", 32'(o_count), 0);
      chk("rst_mid_empty", 32'(o_empty), 1);

      // Randomised traffic against the queue model.
      for (int i = 0; i < 4000; i++) begin
         int phase = (i / 500) % 3;
         logic v = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 3 : 5)));
         logic q = ($urandom_range(0, 9) < (phase == 0 ? 2 : (phase == 1 ? 8 : 5)));
         logic r = ($urandom_range(0, 299) == 0);
         step(r, v, 16'($urandom), q);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Circular-buffer FIFO controller that sits directly upstream of sram16x128 and is its only master.
- Turns a producer-side valid/ready push interface and a consumer-side pop-request interface into the SRAM's addr/we/re/inbits signals.
- Tracks occupancy and returns outbits to the consumer with a valid strobe.
- Fixed 16-bit x 128-entry geometry matching the SRAM.

Parameters:
- DATA_W, 16, data word width (must equal SRAM width)
- ADDR_W, 7, SRAM address width
- DEPTH, 128, entries (2**ADDR_W)

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous, active-high reset
- wr_valid  input  1  producer has a word on wr_data
- wr_data  input  16  push data
- wr_ready  output  1  push accepted this cycle when wr_valid&&wr_ready
- rd_req  input  1  consumer requests one word
- rd_valid  output  1  rd_data valid; registered, one cycle after accepted pop
- rd_data  output  16  pop data, driven directly from sram_out
- full  output  1  count==128
- empty  output  1  count==0
- count  output  8  occupancy, 0..128
- sram_addr  output  7  to SRAM addr
- sram_in  output  16  to SRAM inbits, equals wr_data
- sram_we  output  1  to SRAM we
- sram_re  output  1  to SRAM re
- sram_out  input  16  from SRAM outbits; valid the cycle after sram_re

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; all state updates on the rising clk edge.
- Reset: wr_ptr=0, rd_ptr=0, count=0, rd_valid=0.
- Combinational outputs under reset: wr_ready=0, sram_we=0, sram_re=0, sram_addr=0. full=0 and empty=1 the cycle after reset.
- Single-port arbitration: the SRAM takes one access per cycle.
  - pop_go = rd_req && !empty && !rst.
  - push_go = wr_valid && wr_ready.
  - wr_ready = !rst && !full && !(rd_req && !empty). A pop always wins over a simultaneous push; the push stalls that cycle.
- SRAM drive (combinational, same cycle):
  - pop_go: sram_re=1, sram_we=0, sram_addr=rd_ptr.
  - push_go: sram_we=1, sram_re=0, sram_addr=wr_ptr.
  - Otherwise: both 0, sram_addr=wr_ptr.
- Pointer and count updates at the edge:
  - push_go: wr_ptr+=1, count+=1.
  - pop_go: rd_ptr+=1, count-=1.
  - Pointers are 7-bit and wrap 127->0 naturally.
- Read latency: rd_valid <= pop_go; rd_data = sram_out. Pop-to-data latency is exactly 1 cycle. Back-to-back pops give one word per cycle.
- Empty: rd_req is ignored. No SRAM access, no rd_valid, pointers unchanged, and a pending push proceeds in the same cycle.
- Full: wr_ready=0 and wr_data is not written. Pops proceed normally.
- Count stays within 0..128 by construction; it never wraps.
- Reset mid-operation: an in-flight rd_valid is cleared at the reset edge, and all queued data is discarded (pointers return to 0). SRAM contents are not cleared.

Decomposition:
- Shared package holds DATA_W=16, ADDR_W=7, DEPTH=128 and COUNT_W=ADDR_W+1; sram16x128 and this block both use it.
- No sub-module needed. A generic wrap counter is not worth splitting out.
- The SRAM is instantiated beside this block by the parent, not inside it.

Test Plan:
- Reset, then push 0x1234, 0xBEEF, 0x0001 one per cycle -> sram_we high with sram_addr 0,1,2; count=3; empty=0.
- Pop 3 times back-to-back -> sram_re with addr 0,1,2; rd_data 0x1234, 0xBEEF, 0x0001, each with rd_valid one cycle later; then empty=1, count=0.
- Push 128 words of $random -> full=1, count=128, wr_ready=0. A 129th wr_valid produces no sram_we. Pop all 128 -> data in order, empty=1.
- Wrap: push 100, pop 100, push 60, pop 60 -> writes wrap at addr 127->0 (writes to addr 100..127 then 0..31); data returned in order.
- With count=5, assert wr_valid and rd_req together for 1 cycle -> pop wins, wr_ready=0, count=4; next cycle the push is accepted, count=5.
- Assert rd_req when empty -> no sram_re, no rd_valid. Assert rst during streaming pops -> rd_valid=0, count=0, empty=1 next cycle.
